// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: the pipeline (M) wins by default,
// the debug/loader port (D) is guaranteed progress by a starvation counter and may lock bursts.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [1:0]  m_size,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    output logic        m_stall,
    output logic        m_rvalid,
    output logic [63:0] m_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic        d_lock,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [3:0]    LP_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [LW-1:0] LP_LOCK_MAX     = LW'(LOCK_MAX);

    logic [3:0]    r_starve_cnt;
    logic [LW-1:0] r_lock_cnt;
    logic          r_lock_active;
    logic          r_resp_valid;
    logic          r_resp_owner;

    logic          w_grant_d;
    logic          w_grant_m;
    logic [LW-1:0] w_lock_cnt_nxt;
    logic          w_lock_keep;

    assign w_grant_d = d_req & (~m_req | (r_starve_cnt == LP_STARVE_LIMIT) | r_lock_active);
    assign w_grant_m = m_req & ~w_grant_d;

    assign d_gnt   = w_grant_d;
    assign m_stall = m_req & w_grant_d;
    assign mem_en  = w_grant_d | w_grant_m;

    always_comb begin
        mem_we    = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = 64'd0;
        mem_wdata = 64'd0;
        if (w_grant_d) begin
            mem_we    = d_we;
            mem_size  = d_size;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (w_grant_m) begin
            mem_we    = m_we;
            mem_size  = m_size;
            mem_addr  = m_addr;
            mem_wdata = m_wdata;
        end
    end

    // The grant that starts a burst counts as the first of the LOCK_MAX locked grants.
    assign w_lock_cnt_nxt = (r_lock_active ? r_lock_cnt : '0) + 1'b1;
    assign w_lock_keep    = w_grant_d & d_lock & (w_lock_cnt_nxt < LP_LOCK_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve_cnt  <= 4'd0;
            r_lock_cnt    <= '0;
            r_lock_active <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_owner  <= 1'b0;
        end else begin
            if (w_grant_d || !d_req) begin
                r_starve_cnt <= 4'd0;
            end else if (w_grant_m && (r_starve_cnt != LP_STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            r_lock_active <= w_lock_keep;
            r_lock_cnt    <= w_lock_keep ? w_lock_cnt_nxt : '0;
            r_resp_valid  <= mem_en & ~mem_we;
            r_resp_owner  <= w_grant_d;
        end
    end

    // Read data arrives one cycle after the grant; steer it to whoever issued the read.
    assign m_rvalid = r_resp_valid & ~r_resp_owner;
    assign d_rvalid = r_resp_valid & r_resp_owner;
    assign m_rdata  = m_rvalid ? mem_rdata : 64'd0;
    assign d_rdata  = d_rvalid ? mem_rdata : 64'd0;

endmodule
